// File: rtl/e203_exu_flush_arb.sv
// e203_exu_flush_arb
// N-source pipeline-flush arbiter for the EXU commit stage.
// Source 0 has the highest priority. A source that gets a flush request
// out to the IFU without an immediate ack is locked until the IFU acks or
// the source withdraws. Operands and PC are passed through combinationally
// from the granted source.
//
// state | meaning
// IDLE  | no flush held; arbitrate among src_req each cycle
// HOLD  | lock_r source granted, waiting for pipe_flush_ack

module e203_exu_flush_arb #(
    parameter int NSRC  = 4,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC-1:0]      src_req,
    input  logic [NSRC*XLEN-1:0] src_op1,
    input  logic [NSRC*XLEN-1:0] src_op2,
    input  logic [NSRC*XLEN-1:0] src_pc,
    output logic [NSRC-1:0]      src_ack,
    output logic                 pipe_flush_req,
    input  logic                 pipe_flush_ack,
    output logic [XLEN-1:0]      pipe_flush_add_op1,
    output logic [XLEN-1:0]      pipe_flush_add_op2,
    output logic [XLEN-1:0]      pipe_flush_pc,
    output logic [NSRC-1:0]      pipe_flush_src,
    output logic                 flush_pulse,
    output logic                 flush_busy,
    output logic [CNT_W-1:0]     flush_cnt,
    input  logic                 cnt_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [NSRC-1:0] lock_r;
    logic [NSRC-1:0] arb;
    logic [NSRC-1:0] grant;
    logic            flush_req;
    logic [XLEN-1:0] op1_sel;
    logic [XLEN-1:0] op2_sel;
    logic [XLEN-1:0] pc_sel;

    // Fixed-priority pick: the lowest-index pending request wins.
    always_comb begin
        arb = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                arb    = '0;
                arb[i] = 1'b1;
            end
        end
    end

    // Grant follows the lock while holding; request is masked during reset so
    // the IFU sees the flush drop as soon as reset is asserted.
    always_comb begin
        grant     = (state == HOLD) ? lock_r : arb;
        flush_req = 1'b0;
        if (!rst) begin
            flush_req = (state == HOLD) ? |(src_req & lock_r) : |src_req;
        end
    end

    // One-hot AND-OR mux of the granted source's operands and PC.
    always_comb begin
        op1_sel = '0;
        op2_sel = '0;
        pc_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                op1_sel = op1_sel | src_op1[i*XLEN +: XLEN];
                op2_sel = op2_sel | src_op2[i*XLEN +: XLEN];
                pc_sel  = pc_sel  | src_pc[i*XLEN +: XLEN];
            end
        end
    end

    // Output gating and handshake decode.
    always_comb begin
        pipe_flush_req     = flush_req;
        pipe_flush_src     = grant & {NSRC{flush_req}};
        pipe_flush_add_op1 = flush_req ? op1_sel : '0;
        pipe_flush_add_op2 = flush_req ? op2_sel : '0;
        pipe_flush_pc      = flush_req ? pc_sel  : '0;
        flush_pulse        = flush_req & pipe_flush_ack;
        src_ack            = pipe_flush_src & {NSRC{pipe_flush_ack}};
        flush_busy         = (state == HOLD);
    end

    // Lock the granted source while the IFU has not yet acked; release on ack
    // or when the locked source withdraws its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lock_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req && !pipe_flush_ack) begin
                        state  <= HOLD;
                        lock_r <= grant;
                    end
                end
                HOLD: begin
                    if (!flush_req || pipe_flush_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of completed flushes; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            flush_cnt <= '0;
        end else if (flush_pulse && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Testbench for e203_exu_flush_arb: directed vector table, hand-written
// lock/saturation/reset sequences, then randomized traffic against a
// behavioural model.

module tb_e203_exu_flush_arb;

    localparam int NSRC  = 4;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic                 clk;
    logic                 rst;
    logic [NSRC-1:0]      src_req;
    logic [NSRC*XLEN-1:0] src_op1;
    logic [NSRC*XLEN-1:0] src_op2;
    logic [NSRC*XLEN-1:0] src_pc;
    logic [NSRC-1:0]      src_ack;
    logic                 pipe_flush_req;
    logic                 pipe_flush_ack;
    logic [XLEN-1:0]      pipe_flush_add_op1;
    logic [XLEN-1:0]      pipe_flush_add_op2;
    logic [XLEN-1:0]      pipe_flush_pc;
    logic [NSRC-1:0]      pipe_flush_src;
    logic                 flush_pulse;
    logic                 flush_busy;
    logic [CNT_W-1:0]     flush_cnt;
    logic                 cnt_clr;

    int n_cmp = 0;
    int n_bad = 0;

    e203_exu_flush_arb #(.NSRC(NSRC), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .src_req            (src_req),
        .src_op1            (src_op1),
        .src_op2            (src_op2),
        .src_pc             (src_pc),
        .src_ack            (src_ack),
        .pipe_flush_req     (pipe_flush_req),
        .pipe_flush_ack     (pipe_flush_ack),
        .pipe_flush_add_op1 (pipe_flush_add_op1),
        .pipe_flush_add_op2 (pipe_flush_add_op2),
        .pipe_flush_pc      (pipe_flush_pc),
        .pipe_flush_src     (pipe_flush_src),
        .flush_pulse        (flush_pulse),
        .flush_busy         (flush_busy),
        .flush_cnt          (flush_cnt),
        .cnt_clr            (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Deterministic operand set used by the directed parts.
    function automatic logic [XLEN-1:0] k_op1(int i);
        return 32'(32'h80 * (i + 1));
    endfunction
    function automatic logic [XLEN-1:0] k_op2(int i);
        return 32'(4 * (i + 1));
    endfunction
    function automatic logic [XLEN-1:0] k_pc(int i);
        return 32'h8000_0000 + 32'(i * 32'h40);
    endfunction

    task automatic load_fixed_ops();
        for (int i = 0; i < NSRC; i++) begin
            src_op1[i*XLEN +: XLEN] = k_op1(i);
            src_op2[i*XLEN +: XLEN] = k_op2(i);
            src_pc[i*XLEN +: XLEN]  = k_pc(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        src_req = '0; pipe_flush_ack = 1'b0; cnt_clr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       clr;
        logic       e_req;
        logic [3:0] e_src;
        logic [3:0] e_ack;
        logic       e_pulse;
        logic       e_busy;
        int         e_cnt;
        int         e_idx;
    } vec_t;

    vec_t tbl[14];

    // Behavioural model state for the random phase.
    bit m_busy;
    int m_lock;
    int m_cnt;

    initial begin
        rst = 1'b1; src_req = '0; pipe_flush_ack = 1'b0; cnt_clr = 1'b0;
        load_fixed_ops();
        #2;
        chk("rst_req",   32'(pipe_flush_req), 32'd0);
        chk("rst_src",   32'(pipe_flush_src), 32'd0);
        chk("rst_busy",  32'(flush_busy), 32'd0);
        chk("rst_cnt",   32'(flush_cnt), 32'd0);
        chk("rst_op1",   pipe_flush_add_op1, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //                req      ack   clr   ereq  esrc     eack     epls  ebusy cnt idx
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, -1};
        tbl[1]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 0,  1};
        tbl[2]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1,  2};
        tbl[3]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 1,  2};
        tbl[4]  = '{4'b0101, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 1,  2};
        tbl[5]  = '{4'b0101, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 2,  0};
        tbl[6]  = '{4'b1110, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 3,  1};
        tbl[7]  = '{4'b1110, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 3,  1};
        tbl[8]  = '{4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 4,  3};
        tbl[9]  = '{4'b0111, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4, -1};
        tbl[10] = '{4'b0111, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 4,  0};
        tbl[11] = '{4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 4,  0};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, -1};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, -1};

        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            src_req = tbl[k].req; pipe_flush_ack = tbl[k].ack; cnt_clr = tbl[k].clr;
            #2;
            chk($sformatf("v%0d_req", k),   32'(pipe_flush_req), 32'(tbl[k].e_req));
            chk($sformatf("v%0d_src", k),   32'(pipe_flush_src), 32'(tbl[k].e_src));
            chk($sformatf("v%0d_ack", k),   32'(src_ack),        32'(tbl[k].e_ack));
            chk($sformatf("v%0d_pulse", k), 32'(flush_pulse),    32'(tbl[k].e_pulse));
            chk($sformatf("v%0d_busy", k),  32'(flush_busy),     32'(tbl[k].e_busy));
            chk($sformatf("v%0d_cnt", k),   32'(flush_cnt),      32'(tbl[k].e_cnt));
            chk($sformatf("v%0d_op1", k),   pipe_flush_add_op1, (tbl[k].e_idx < 0) ? 32'd0 : k_op1(tbl[k].e_idx));
            chk($sformatf("v%0d_op2", k),   pipe_flush_add_op2, (tbl[k].e_idx < 0) ? 32'd0 : k_op2(tbl[k].e_idx));
            chk($sformatf("v%0d_pc", k),    pipe_flush_pc,      (tbl[k].e_idx < 0) ? 32'd0 : k_pc(tbl[k].e_idx));
        end

        // Counter saturation: 17 zero-wait flushes into a 4-bit counter.
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            src_req = 4'b0100; pipe_flush_ack = 1'b1; cnt_clr = 1'b0;
        end
        @(negedge clk);
        src_req = '0; pipe_flush_ack = 1'b0;
        #2;
        chk("sat_cnt", 32'(flush_cnt), 32'(CMAX));

        // Async reset while holding source 3.
        @(negedge clk);
        src_req = 4'b1000; pipe_flush_ack = 1'b0;
        @(negedge clk);
        #2;
        chk("hold3_busy", 32'(flush_busy), 32'd1);
        chk("hold3_req",  32'(pipe_flush_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_req",  32'(pipe_flush_req), 32'd0);
        chk("arst_busy", 32'(flush_busy), 32'd0);
        chk("arst_cnt",  32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rearb_req",  32'(pipe_flush_req), 32'd1);
        chk("rearb_src",  32'(pipe_flush_src), 32'b1000);
        chk("rearb_busy", 32'(flush_busy), 32'd0);
        chk("rearb_pc",   pipe_flush_pc, k_pc(3));
        @(negedge clk);
        pipe_flush_ack = 1'b1;
        #2;
        chk("rearb_ack", 32'(src_ack), 32'b1000);
        // Clear together with a flush pulse: clear wins.
        @(negedge clk);
        src_req = 4'b0010; pipe_flush_ack = 1'b1; cnt_clr = 1'b1;
        #2;
        chk("clr_pulse", 32'(flush_pulse), 32'd1);
        chk("clr_pre",   32'(flush_cnt), 32'd1);
        @(negedge clk);
        src_req = '0; pipe_flush_ack = 1'b0; cnt_clr = 1'b0;
        #2;
        chk("clr_post", 32'(flush_cnt), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        m_busy = 1'b0; m_lock = 0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            int         gidx;
            bit         ereq;
            bit         epulse;
            logic [3:0] esrc;
            logic [3:0] nreq;
            @(negedge clk);
            for (int i = 0; i < NSRC; i++) begin
                if (!src_req[i]) begin
                    src_op1[i*XLEN +: XLEN] = $urandom;
                    src_op2[i*XLEN +: XLEN] = $urandom;
                    src_pc[i*XLEN +: XLEN]  = $urandom;
                end
            end
            nreq = 4'($urandom);
            if ($urandom_range(0, 3) == 0) nreq = '0;
            src_req        = nreq;
            pipe_flush_ack = ($urandom_range(0, 2) == 0);
            cnt_clr        = ($urandom_range(0, 40) == 0);
            #2;
            gidx = -1;
            if (m_busy) begin
                gidx = m_lock;
            end else begin
                for (int i = NSRC - 1; i >= 0; i--) if (src_req[i]) gidx = i;
            end
            ereq   = (gidx >= 0) && src_req[gidx];
            epulse = ereq && pipe_flush_ack;
            esrc   = ereq ? 4'(1 << gidx) : 4'b0000;
            chk("rnd_req",   32'(pipe_flush_req), 32'(ereq));
            chk("rnd_src",   32'(pipe_flush_src), 32'(esrc));
            chk("rnd_ack",   32'(src_ack), pipe_flush_ack ? 32'(esrc) : 32'd0);
            chk("rnd_pulse", 32'(flush_pulse), 32'(epulse));
            chk("rnd_busy",  32'(flush_busy), 32'(m_busy));
            chk("rnd_cnt",   32'(flush_cnt), 32'(m_cnt));
            chk("rnd_op1",   pipe_flush_add_op1, ereq ? src_op1[gidx*XLEN +: XLEN] : 32'd0);
            chk("rnd_op2",   pipe_flush_add_op2, ereq ? src_op2[gidx*XLEN +: XLEN] : 32'd0);
            chk("rnd_pc",    pipe_flush_pc,      ereq ? src_pc[gidx*XLEN +: XLEN]  : 32'd0);
            if (cnt_clr) m_cnt = 0;
            else if (epulse && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (!m_busy) begin
                if (ereq && !pipe_flush_ack) begin
                    m_busy = 1'b1;
                    m_lock = gidx;
                end
            end else begin
                m_busy = ereq && !pipe_flush_ack;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
